// File: rtl/apb_pkg.sv
// Shared APB completer definitions: phase encoding, wait-state limits, alignment helper.
package apb_pkg;

    localparam int unsigned MAX_WS = 63;
    localparam int unsigned WS_W   = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // True when the byte-offset bits below the word boundary are all zero.
    function automatic logic valid_align(input logic [31:0] addr, input int unsigned align_bits);
        logic [31:0] mask;
        mask = (32'd1 << align_bits) - 32'd1;
        return (addr & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/apb_regbank_peripheral_if.sv
// APB bus bundle between a requester and a completer.
interface apb_regbank_peripheral_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_wait_counter.sv
// Load/decrement wait-state counter with a registered zero flag.
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [WS_W-1:0] load_val_i,
    input  logic            dec_i,
    output logic            zero_o
);

    logic [WS_W-1:0] cnt_q;
    logic            zero_q;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (load_i) begin
            cnt_q  <= load_val_i;
            zero_q <= (load_val_i == '0);
        end else if (dec_i && !zero_q) begin
            cnt_q  <= cnt_q - WS_W'(1);
            zero_q <= (cnt_q == WS_W'(1));
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/apb_regbank_peripheral.sv
// Parametrised APB register-bank completer with wait states, byte strobes and error reporting.
module apb_regbank_peripheral
    import apb_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter int unsigned          NUM_REGS   = 16,
    parameter int unsigned          RD_WS      = 0,
    parameter int unsigned          WR_WS      = 1,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic                     pclk,
    input  logic                     presetn,
    apb_regbank_peripheral_if.slave  apb
);

    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned ALIGNBITS = $clog2(STRB_W);
    localparam int unsigned IDX_W     = ADDR_WIDTH - ALIGNBITS;
    localparam int unsigned REG_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Reject unsupported configurations at elaboration.
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
        $error("apb_regbank_peripheral: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (64'(NUM_REGS) > (64'd1 << IDX_W)) begin : g_bad_nregs
        $error("apb_regbank_peripheral: NUM_REGS does not fit in the address space");
    end
    if (RD_WS > MAX_WS || WR_WS > MAX_WS) begin : g_bad_ws
        $error("apb_regbank_peripheral: wait states limited to 63");
    end

    apb_state_e             state_q, state_d, phase_c;
    logic                   wr_q, wr_d;
    logic                   err_q, err_d;
    logic [REG_W-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];

    logic [IDX_W-1:0]       idx_c;
    logic                   range_ok_c;
    logic                   setup_err_c;
    logic                   load_c;
    logic [WS_W-1:0]        load_val_c;
    logic                   dec_c;
    logic                   we_c;
    logic                   ws_zero;

    assign idx_c      = apb.paddr[ADDR_WIDTH-1:ALIGNBITS];
    assign range_ok_c = (64'(idx_c) < 64'(NUM_REGS));
    assign setup_err_c = !valid_align(32'(apb.paddr), ALIGNBITS)
                       || !range_ok_c
                       || (apb.pwrite && range_ok_c && RO_MASK[REG_W'(idx_c)])
                       || apb.penable;

    apb_wait_counter u_wait_counter (
        .clk        (pclk),
        .rst_n      (presetn),
        .load_i     (load_c),
        .load_val_i (load_val_c),
        .dec_i      (dec_c),
        .zero_o     (ws_zero)
    );

    // State and latched transfer context.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    // Phase decode and next state; SETUP is the cycle psel&!penable is seen from IDLE,
    // so a zero-wait transfer completes in the following cycle.
    always_comb begin
        phase_c    = state_q;
        state_d    = state_q;
        wr_d       = wr_q;
        err_d      = err_q;
        idx_d      = idx_q;
        load_c     = 1'b0;
        load_val_c = '0;
        dec_c      = 1'b0;
        we_c       = 1'b0;

        if (state_q == IDLE && apb.psel && !apb.penable) begin
            phase_c = SETUP;
        end

        unique case (phase_c)
            IDLE: begin
                state_d = IDLE;
            end
            SETUP: begin
                wr_d       = apb.pwrite;
                idx_d      = REG_W'(idx_c);
                err_d      = setup_err_c;
                load_c     = 1'b1;
                load_val_c = apb.pwrite ? WS_W'(WR_WS) : WS_W'(RD_WS);
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (!ws_zero) begin
                    dec_c = 1'b1;
                end else if (apb.penable) begin
                    we_c    = wr_q && !err_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register array with byte-lane merge on write completion.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (we_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (apb.pstrb[b]) begin
                    regs_q[idx_q][8*b +: 8] <= apb.pwdata[8*b +: 8];
                end
            end
        end
    end

    assign apb.pready  = (state_q == ACCESS) && ws_zero;
    assign apb.pslverr = apb.pready && err_q;
    assign apb.prdata  = (apb.pready && !err_q && !wr_q) ? regs_q[idx_q] : '0;

endmodule
